// File: rtl/code_lock_sender_pkg.sv
// Shared definitions for the code-lock sender: FSM state encoding,
// the attempt counter width and the default code width shared with the lock.
package code_lock_pkg;

  localparam int ATTEMPT_W  = 8;
  localparam int CODE_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_PRESENT = 3'd2,
    ST_WAIT    = 3'd3,
    ST_REPORT  = 3'd4
  } state_e;

  // Larger of two integers, used to size the shared phase timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/code_lock_sender_if.sv
// Bus between an attempt requester / lock macro and the code-lock sender.
// Optional macro CODE_LOCK_SENDER_SCAN_EN adds last_code_o.
//
// Handshake: an attempt is accepted on the rising clock edge where
// start_i=1 and ready_o=1; code_i is sampled on that same edge. start_i
// seen while ready_o=0 is dropped, never queued. done_o pulses for one
// cycle when the attempt ends; pass_o is valid from that cycle and stays
// stable until the next accepted start.
interface code_lock_sender_if
  import code_lock_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF
);
  logic                 start_i;
  logic [CODE_W-1:0]    code_i;
  logic                 ready_o;
  logic                 clear_o;
  logic [CODE_W-1:0]    code_o;
  logic                 unlocked_i;
  logic                 done_o;
  logic                 pass_o;
  logic [ATTEMPT_W-1:0] attempts_o;
`ifdef CODE_LOCK_SENDER_SCAN_EN
  logic [CODE_W-1:0]    last_code_o;

  modport slave (
    input  start_i, code_i, unlocked_i,
    output ready_o, clear_o, code_o, done_o, pass_o, attempts_o, last_code_o
  );
  modport master (
    output start_i, code_i, unlocked_i,
    input  ready_o, clear_o, code_o, done_o, pass_o, attempts_o, last_code_o
  );
`else
  modport slave (
    input  start_i, code_i, unlocked_i,
    output ready_o, clear_o, code_o, done_o, pass_o, attempts_o
  );
  modport master (
    output start_i, code_i, unlocked_i,
    input  ready_o, clear_o, code_o, done_o, pass_o, attempts_o
  );
`endif
endinterface

// File: rtl/code_lock_sender_timer.sv
// Loadable up-counter with a terminal-count flag; reused for the
// code-hold phase and the response window of the code-lock sender.
module code_lock_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;

  // Load to zero has priority over counting.
  always_ff @(posedge clk) begin
    if (rst)         count_q <= '0;
    else if (load_i) count_q <= '0;
    else if (en_i)   count_q <= count_q + 1'b1;
  end

  assign tc_o = (count_q == term_i);

endmodule

// File: rtl/code_lock_sender.sv
// Code-lock sender: clears the lock, presents a code for HOLD_CYC cycles,
// then waits up to TIMEOUT_CYC cycles for the unlocked status.
// Optional macro CODE_LOCK_SENDER_SCAN_EN: on a fail, try the next code
// (mod 2^CODE_W) until a pass or every code has been tried.
module code_lock_sender
  import code_lock_pkg::*;
#(
  parameter int CODE_W      = CODE_W_DEF,
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  code_lock_sender_if.slave    bus,
  output state_e               state_o
);

  localparam int TMR_W = $clog2(max_int(HOLD_CYC, TIMEOUT_CYC) + 1);
  localparam logic [TMR_W-1:0] HOLD_TERM = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] WAIT_TERM = TMR_W'(TIMEOUT_CYC - 1);

  state_e               state_q;
  logic                 ready_q;
  logic                 clear_q;
  logic [CODE_W-1:0]    code_out_q;
  logic [CODE_W-1:0]    code_q;
  logic                 done_q;
  logic                 pass_q;
  logic [ATTEMPT_W-1:0] attempts_q;
`ifdef CODE_LOCK_SENDER_SCAN_EN
  logic [CODE_W-1:0]    tries_q;
  logic [CODE_W-1:0]    last_q;
`endif

  logic             tmr_load_d;
  logic             tmr_en_d;
  logic [TMR_W-1:0] tmr_term_d;
  logic             tmr_tc;

  // Timer control: held at zero outside the timed phases, reloaded when
  // the hold phase ends so the response window starts from zero.
  always_comb begin
    tmr_load_d = 1'b0;
    tmr_en_d   = 1'b0;
    tmr_term_d = WAIT_TERM;
    case (state_q)
      ST_IDLE, ST_CLEAR: tmr_load_d = 1'b1;
      ST_PRESENT: begin
        tmr_term_d = HOLD_TERM;
        tmr_en_d   = 1'b1;
        tmr_load_d = tmr_tc;
      end
      ST_WAIT: tmr_en_d = 1'b1;
      default: ;
    endcase
  end

  code_lock_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load_d),
    .en_i   (tmr_en_d),
    .term_i (tmr_term_d),
    .tc_o   (tmr_tc)
  );

  // Attempt sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      clear_q    <= 1'b0;
      code_out_q <= '0;
      code_q     <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      attempts_q <= '0;
`ifdef CODE_LOCK_SENDER_SCAN_EN
      tries_q    <= '0;
      last_q     <= '0;
`endif
    end else begin
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            code_q     <= bus.code_i;
            pass_q     <= 1'b0;
            ready_q    <= 1'b0;
            clear_q    <= 1'b1;
            code_out_q <= '0;
            state_q    <= ST_CLEAR;
`ifdef CODE_LOCK_SENDER_SCAN_EN
            tries_q    <= '0;
`endif
          end
        end
        ST_CLEAR: begin
          code_out_q <= code_q;
          state_q    <= ST_PRESENT;
        end
        // unlocked_i is stale while the lock is still settling on the code.
        ST_PRESENT: begin
          if (tmr_tc) state_q <= ST_WAIT;
        end
        // A late unlock in the last window cycle still counts as a pass.
        ST_WAIT: begin
          if (bus.unlocked_i || tmr_tc) begin
            if (attempts_q != '1) attempts_q <= attempts_q + 1'b1;
`ifdef CODE_LOCK_SENDER_SCAN_EN
            last_q <= code_q;
            if (bus.unlocked_i || (tries_q == '1)) begin
              pass_q  <= bus.unlocked_i;
              done_q  <= 1'b1;
              state_q <= ST_REPORT;
            end else begin
              code_q     <= code_q + 1'b1;
              tries_q    <= tries_q + 1'b1;
              clear_q    <= 1'b1;
              code_out_q <= '0;
              state_q    <= ST_CLEAR;
            end
`else
            pass_q  <= bus.unlocked_i;
            done_q  <= 1'b1;
            state_q <= ST_REPORT;
`endif
          end
        end
        ST_REPORT: begin
          code_out_q <= '0;
          ready_q    <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_o    = ready_q;
  assign bus.clear_o    = clear_q;
  assign bus.code_o     = code_out_q;
  assign bus.done_o     = done_q;
  assign bus.pass_o     = pass_q;
  assign bus.attempts_o = attempts_q;
`ifdef CODE_LOCK_SENDER_SCAN_EN
  assign bus.last_code_o = last_q;
`endif
  assign state_o = state_q;

endmodule

// File: tb/tb_code_lock_sender.sv
// Directed bench for code_lock_sender (HOLD_CYC=4, TIMEOUT_CYC=16).
// Cycle numbering: the cycle after the accepting edge is rel=1.
module tb_code_lock_sender;
  import code_lock_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e state_o;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     t_edge = 0;

  logic       lock_en = 1'b0;
  logic [2:0] lock_code = 3'b000;
  logic       lock_open = 1'b0;

  code_lock_sender_if #(.CODE_W(3)) bus ();

  code_lock_sender #(.CODE_W(3), .HOLD_CYC(4), .TIMEOUT_CYC(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Lock model: cleared by clear_o, opens one cycle after seeing its code.
  always @(posedge clk) begin
    if (!lock_en || bus.clear_o) lock_open <= 1'b0;
    else if (bus.code_o == lock_code) lock_open <= 1'b1;
  end
  assign bus.unlocked_i = lock_open;

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    @(negedge clk);
    for (int i = 0; i < 50 && !bus.ready_o; i++) @(negedge clk);
  endtask

  task automatic start_attempt(input logic [2:0] code);
    wait_ready();
    bus.start_i = 1'b1;
    bus.code_i  = code;
    @(negedge clk);
    bus.start_i = 1'b0;
    t_edge = cyc;
  endtask

  task automatic wait_done(input int max_cyc, output int rel, output bit seen);
    seen = 1'b0;
    rel  = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        seen = 1'b1;
        rel  = cyc - t_edge + 1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready_o); end
    checks++; if (bus.clear_o !== 1'b0) begin errors++; $display("FAIL reset_clear: got %b expected 0", bus.clear_o); end
    checks++; if (bus.code_o !== 3'b000) begin errors++; $display("FAIL reset_code: got %b expected 000", bus.code_o); end
    checks++; if (bus.done_o !== 1'b0 || bus.pass_o !== 1'b0) begin errors++; $display("FAIL reset_done_pass: got %b%b expected 00", bus.done_o, bus.pass_o); end
    checks++; if (bus.attempts_o !== 8'd0) begin errors++; $display("FAIL reset_attempts: got %0d expected 0", bus.attempts_o); end
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_o, ST_IDLE); end
  endtask

  task automatic test_pass();
    int rel; bit seen;
    lock_en = 1'b1; lock_code = 3'b101;
    start_attempt(3'b101);
    checks++; if (bus.clear_o !== 1'b1 || bus.code_o !== 3'b000) begin errors++; $display("FAIL pass_clear_rel1: got clear=%b code=%b expected clear=1 code=000", bus.clear_o, bus.code_o); end
    @(negedge clk);
    checks++; if (bus.code_o !== 3'b101 || bus.clear_o !== 1'b0) begin errors++; $display("FAIL pass_code_rel2: got code=%b clear=%b expected code=101 clear=0", bus.code_o, bus.clear_o); end
    wait_done(30, rel, seen);
    checks++; if (!seen || rel != 7) begin errors++; $display("FAIL pass_done_time: got rel=%0d expected 7", rel); end
    checks++; if (bus.pass_o !== 1'b1) begin errors++; $display("FAIL pass_result: got %b expected 1", bus.pass_o); end
    checks++; if (bus.attempts_o !== 8'd1) begin errors++; $display("FAIL pass_attempts: got %0d expected 1", bus.attempts_o); end
    @(negedge clk);
    checks++; if (bus.ready_o !== 1'b1 || bus.pass_o !== 1'b1 || bus.done_o !== 1'b0) begin errors++; $display("FAIL pass_after: got ready=%b pass=%b done=%b expected 1 1 0", bus.ready_o, bus.pass_o, bus.done_o); end
  endtask

  task automatic test_timeout();
    int rel; bit seen;
    lock_en = 1'b0;
    start_attempt(3'b011);
    wait_done(40, rel, seen);
    checks++; if (!seen || rel != 22) begin errors++; $display("FAIL timeout_done_time: got rel=%0d expected 22", rel); end
    checks++; if (bus.pass_o !== 1'b0) begin errors++; $display("FAIL timeout_result: got %b expected 0", bus.pass_o); end
    checks++; if (bus.code_o !== 3'b011) begin errors++; $display("FAIL timeout_code_report: got %b expected 011", bus.code_o); end
    checks++; if (bus.attempts_o !== 8'd2) begin errors++; $display("FAIL timeout_attempts: got %0d expected 2", bus.attempts_o); end
    @(negedge clk);
    checks++; if (bus.code_o !== 3'b000 || bus.ready_o !== 1'b1) begin errors++; $display("FAIL timeout_rel23: got code=%b ready=%b expected 000 1", bus.code_o, bus.ready_o); end
  endtask

  task automatic test_busy_ignore();
    int dones = 0; int done_rel = -1; int extra_clear = 0; int rel; bit seen;
    lock_en = 1'b1; lock_code = 3'b101;
    start_attempt(3'b101);
    @(negedge clk);
    @(negedge clk);
    bus.start_i = 1'b1;
    for (int r = 4; r <= 8; r++) begin
      @(negedge clk);
      if (bus.done_o) begin dones++; done_rel = cyc - t_edge + 1; end
      if (bus.clear_o) extra_clear++;
    end
    checks++; if (dones != 1 || done_rel != 7) begin errors++; $display("FAIL busy_one_done: got dones=%0d rel=%0d expected 1 at 7", dones, done_rel); end
    checks++; if (extra_clear != 0) begin errors++; $display("FAIL busy_no_reaccept: got clears=%0d expected 0", extra_clear); end
    checks++; if (bus.attempts_o !== 8'd3 || bus.ready_o !== 1'b1) begin errors++; $display("FAIL busy_rel8: got attempts=%0d ready=%b expected 3 1", bus.attempts_o, bus.ready_o); end
    @(negedge clk);
    bus.start_i = 1'b0;
    t_edge = cyc;
    checks++; if (bus.clear_o !== 1'b1) begin errors++; $display("FAIL busy_idle_accept: got clear=%b expected 1", bus.clear_o); end
    wait_done(30, rel, seen);
    checks++; if (!seen || rel != 7 || bus.attempts_o !== 8'd4) begin errors++; $display("FAIL busy_second: got rel=%0d attempts=%0d expected 7 4", rel, bus.attempts_o); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    lock_en = 1'b0;
    start_attempt(3'b010);
    repeat (9) @(negedge clk);
    checks++; if (state_o !== ST_WAIT) begin errors++; $display("FAIL rstmid_in_wait: got %0d expected %0d", state_o, ST_WAIT); end
    rst = 1'b1;
    @(negedge clk); if (bus.done_o) dones++;
    @(negedge clk); if (bus.done_o) dones++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.ready_o !== 1'b1 || bus.code_o !== 3'b000 || bus.clear_o !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got ready=%b code=%b clear=%b expected 1 000 0", bus.ready_o, bus.code_o, bus.clear_o); end
    checks++; if (bus.attempts_o !== 8'd0) begin errors++; $display("FAIL rstmid_attempts: got %0d expected 0", bus.attempts_o); end
    for (int i = 0; i < 30; i++) begin if (bus.done_o) dones++; @(negedge clk); end
    checks++; if (dones != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d done pulses expected 0", dones); end
  endtask

  task automatic test_saturation();
    int n = 0;
    lock_en = 1'b1; lock_code = 3'b101;
    wait_ready();
    bus.code_i  = 3'b101;
    bus.start_i = 1'b1;
    for (int i = 0; i < 4000 && n < 260; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        n++;
        if (n == 254) begin
          checks++; if (bus.attempts_o !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", bus.attempts_o); end
        end
        if (n == 255) begin
          checks++; if (bus.attempts_o !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", bus.attempts_o); end
        end
      end
    end
    bus.start_i = 1'b0;
    checks++; if (n != 260) begin errors++; $display("FAIL sat_count: got %0d attempts done expected 260", n); end
    checks++; if (bus.attempts_o !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", bus.attempts_o); end
  endtask

`ifdef CODE_LOCK_SENDER_SCAN_EN
  task automatic test_scan_found();
    int dones = 0;
    pulse_reset();
    lock_en = 1'b1; lock_code = 3'b110;
    start_attempt(3'b000);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
      if (bus.ready_o) break;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL scan_one_done: got %0d expected 1", dones); end
    checks++; if (bus.pass_o !== 1'b1 || bus.last_code_o !== 3'b110) begin errors++; $display("FAIL scan_found: got pass=%b last=%b expected 1 110", bus.pass_o, bus.last_code_o); end
    checks++; if (bus.attempts_o !== 8'd7) begin errors++; $display("FAIL scan_attempts: got %0d expected 7", bus.attempts_o); end
  endtask

  task automatic test_scan_none();
    int rel; bit seen;
    pulse_reset();
    lock_en = 1'b0;
    start_attempt(3'b000);
    wait_done(400, rel, seen);
    checks++; if (!seen || bus.pass_o !== 1'b0) begin errors++; $display("FAIL scan_none_result: got seen=%b pass=%b expected 1 0", seen, bus.pass_o); end
    checks++; if (bus.attempts_o !== 8'd8 || bus.last_code_o !== 3'b111) begin errors++; $display("FAIL scan_none_attempts: got %0d last=%b expected 8 111", bus.attempts_o, bus.last_code_o); end
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    bus.start_i = 1'b0;
    bus.code_i  = 3'b000;
    test_reset();
    test_pass();
`ifndef CODE_LOCK_SENDER_SCAN_EN
    test_timeout();
    test_busy_ignore();
`endif
    test_reset_mid();
    test_saturation();
`ifdef CODE_LOCK_SENDER_SCAN_EN
    test_scan_found();
    test_scan_none();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
